// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_pkg
//  Description : Shared constants and state type for the scanline pixel
//                buffer read side (80x64 -> 1280x4 buffer).
//  Revision    : 1.0  initial release
// ============================================================================
package pixel_pkg;

    localparam int PIXELS_PER_LINE = 1280;
    localparam int PIXEL_WIDTH     = 4;
    localparam int LINE_ADDR_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } reader_state_t;

endpackage
`default_nettype wire

// File: rtl/line_addr_counter.sv
`default_nettype none
// ============================================================================
//  Module      : line_addr_counter
//  Description : Scanline address counter with per-address repeat count.
//                Holds each address for REPEAT advance cycles, then steps.
//                Saturates on the final address/repeat and flags it via
//                o_last. Shared by the read sweep and the write-side packer.
//  Revision    : 1.0  initial release
// ============================================================================
module line_addr_counter #(
    parameter int DEPTH      = 1280,
    parameter int ADDR_WIDTH = 11,
    parameter int REPEAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_advance,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    localparam int                    c_rep_width = $clog2(REPEAT + 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_max  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [c_rep_width-1:0] c_rep_max  = c_rep_width'(REPEAT - 1);

    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [c_rep_width-1:0] r_rep;
    logic                   w_rep_end;
    logic                   w_last;

    assign w_rep_end = (r_rep == c_rep_max);
    assign w_last    = (r_addr == c_addr_max) && w_rep_end;

    // Address/repeat stepping; once the final slot is reached both counters hold.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_addr <= '0;
            r_rep  <= '0;
        end else if (i_advance && !w_last) begin
            if (w_rep_end) begin
                r_rep  <= '0;
                r_addr <= r_addr + ADDR_WIDTH'(1);
            end else begin
                r_rep  <= r_rep + c_rep_width'(1);
            end
        end
    end

    assign o_addr = r_addr;
    assign o_last = w_last;

endmodule
`default_nettype wire

// File: rtl/pixel_line_reader.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_line_reader
//  Description : Read side of the scanline pixel buffer. On line_start sweeps
//                the read port from pixel 0 to PIXELS-1, compensates the
//                1-cycle RAM read latency and emits an aligned pixel /
//                pixel_valid stream with optional horizontal repeat.
//  Config      : `PIXEL_LINE_READER_BANK_SWAP_EN -- when defined, bank
//                toggles at each line_done (ping-pong buffer halves);
//                otherwise bank is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_line_reader #(
    parameter int                     PIXELS      = pixel_pkg::PIXELS_PER_LINE,
    parameter int                     ADDR_WIDTH  = pixel_pkg::LINE_ADDR_WIDTH,
    parameter int                     PIXEL_WIDTH = pixel_pkg::PIXEL_WIDTH,
    parameter int                     REPEAT      = 1,
    parameter logic [PIXEL_WIDTH-1:0] BLANK_VALUE = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   line_start,
    output logic [ADDR_WIDTH-1:0]  pixel_addr,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    output logic [PIXEL_WIDTH-1:0] pixel,
    output logic                   pixel_valid,
    output logic                   busy,
    output logic                   line_done,
    output logic                   overrun,
    output logic                   bank
);

    import pixel_pkg::*;

    reader_state_t          r_state;
    reader_state_t          w_next_state;
    logic                   r_drain_cnt;
    logic                   w_issue;
    logic                   w_clear;
    logic                   w_busy;
    logic                   w_last;
    logic                   r_issue_d;
    logic                   r_last_d;
    logic [PIXEL_WIDTH-1:0] r_pixel;
    logic                   r_pixel_valid;
    logic                   r_line_done;
    logic                   r_overrun;

    line_addr_counter #(
        .DEPTH      (PIXELS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REPEAT     (REPEAT)
    ) u_addr_counter (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_clear),
        .i_advance (w_issue),
        .o_addr    (pixel_addr),
        .o_last    (w_last)
    );

    // State register plus the two-cycle drain timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_drain_cnt <= (r_state == DRAIN) ? ~r_drain_cnt : 1'b0;
        end
    end

    // Next-state: sweep until the final slot is issued, then flush two cycles.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (line_start)  w_next_state = READ;
            READ:    if (w_last)      w_next_state = DRAIN;
            DRAIN:   if (r_drain_cnt) w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // State-decoded controls: issue a read every READ cycle, rewind address on IDLE entry.
    always_comb begin
        w_issue = 1'b0;
        w_clear = 1'b0;
        w_busy  = 1'b1;
        case (r_state)
            IDLE: begin
                w_clear = 1'b1;
                w_busy  = 1'b0;
            end
            READ:    w_issue = 1'b1;
            DRAIN:   w_clear = r_drain_cnt;
            default: begin
                w_clear = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    // Latency pipe: the issue/last flags trail the address by one cycle to meet the RAM data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_d     <= 1'b0;
            r_last_d      <= 1'b0;
            r_pixel       <= BLANK_VALUE;
            r_pixel_valid <= 1'b0;
            r_line_done   <= 1'b0;
        end else begin
            r_issue_d     <= w_issue;
            r_last_d      <= w_issue && w_last;
            r_pixel       <= r_issue_d ? pixel_data : BLANK_VALUE;
            r_pixel_valid <= r_issue_d;
            r_line_done   <= r_last_d;
        end
    end

    // Sticky overrun: a line_start that lands while a line is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (line_start && (r_state != IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

`ifdef PIXEL_LINE_READER_BANK_SWAP_EN
    logic r_bank;

    // Ping-pong: flip halves in the same cycle line_done is raised.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank <= 1'b0;
        end else if (r_last_d) begin
            r_bank <= ~r_bank;
        end
    end

    assign bank = r_bank;
`else
    assign bank = 1'b0;
`endif

    assign pixel       = r_pixel;
    assign pixel_valid = r_pixel_valid;
    assign busy        = w_busy;
    assign line_done   = r_line_done;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_pixel_line_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_line_reader
//  Description : Directed-sequence bench for pixel_line_reader with random
//                buffer contents. Two instances: REPEAT=1 (blank 0xA) and
//                REPEAT=2 (blank 0). Expected streams are computed from
//                line_start timing and buffer contents.
//  Config      : honours `PIXEL_LINE_READER_BANK_SWAP_EN for bank checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_line_reader;

    localparam int             P      = 1280;
    localparam int             AW     = 11;
    localparam int             PW     = 4;
    localparam logic [PW-1:0]  BLANK1 = 4'hA;
    localparam logic [PW-1:0]  BLANK2 = 4'h0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          ls    = 1'b0;
    logic          sel   = 1'b0;
    logic          ls1, ls2;
    logic [AW-1:0] addr1, addr2;
    logic [PW-1:0] rd1, rd2, pix1, pix2;
    logic          v1, v2, b1, b2, d1, d2, o1, o2, k1, k2;

    logic [PW-1:0] mem [P];
    logic          mb [2];

    int n_tests = 0;
    int n_fail  = 0;

    // synchronous-read buffer models, one per instance
    always @(posedge clk) begin
        rd1 <= mem[addr1];
        rd2 <= mem[addr2];
    end

    assign ls1 = ls & ~sel;
    assign ls2 = ls & sel;

    pixel_line_reader #(.REPEAT(1), .BLANK_VALUE(BLANK1)) dut1 (
        .clk(clk), .reset(reset), .line_start(ls1), .pixel_addr(addr1),
        .pixel_data(rd1), .pixel(pix1), .pixel_valid(v1), .busy(b1),
        .line_done(d1), .overrun(o1), .bank(k1)
    );

    pixel_line_reader #(.REPEAT(2), .BLANK_VALUE(BLANK2)) dut2 (
        .clk(clk), .reset(reset), .line_start(ls2), .pixel_addr(addr2),
        .pixel_data(rd2), .pixel(pix2), .pixel_valid(v2), .busy(b2),
        .line_done(d2), .overrun(o2), .bank(k2)
    );

    // observed signals of the selected instance
    logic [AW-1:0] s_addr;
    logic [PW-1:0] s_pix, s_blank;
    logic          s_v, s_busy, s_done, s_ovr, s_bank;
    assign s_addr  = sel ? addr2 : addr1;
    assign s_pix   = sel ? pix2  : pix1;
    assign s_v     = sel ? v2    : v1;
    assign s_busy  = sel ? b2    : b1;
    assign s_done  = sel ? d2    : d1;
    assign s_ovr   = sel ? o2    : o1;
    assign s_bank  = sel ? k2    : k1;
    assign s_blank = sel ? BLANK2 : BLANK1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  32'(s_addr), 0);
        chk({tag, "_pixel"}, 32'(s_pix),  32'(s_blank));
        chk({tag, "_valid"}, 32'(s_v),    0);
        chk({tag, "_busy"},  32'(s_busy), 0);
        chk({tag, "_done"},  32'(s_done), 0);
        chk({tag, "_ovr"},   32'(s_ovr),  0);
        chk({tag, "_bank"},  32'(s_bank), 0);
    endtask

    // One line for the selected instance, entered and left at a falling edge.
    // Index i = cycle after the (i)th edge following the line_start edge.
    task automatic run_line(input int rep, input bit rnd, input int inject_at, input int reset_at);
        int            pr, nvalid, nv_err, np_err, ndone, done_idx, nbusy_err, nbank_err, maxaddr, quiet;
        logic          exp_v, exp_bank;
        logic [PW-1:0] exp_pix;
        pr = P * rep;
        nvalid = 0; nv_err = 0; np_err = 0; ndone = 0; done_idx = -1;
        nbusy_err = 0; nbank_err = 0; maxaddr = 0;
        for (int k = 0; k < P; k++) mem[k] = rnd ? PW'($urandom) : PW'(k % 16);
        ls = 1'b1;
        for (int i = 0; i <= pr + 2; i++) begin
            @(negedge clk);
            ls = (i == inject_at);
            exp_v   = (i >= 2) && (i < pr + 2);
            exp_pix = exp_v ? mem[(i - 2) / rep] : s_blank;
`ifdef PIXEL_LINE_READER_BANK_SWAP_EN
            exp_bank = (i >= pr + 1) ? ~mb[sel] : mb[sel];
`else
            exp_bank = 1'b0;
`endif
            if (s_v === 1'b1) nvalid++;
            if (s_v !== exp_v) nv_err++;
            if (s_pix !== exp_pix) np_err++;
            if (s_done === 1'b1) begin ndone++; done_idx = i; end
            if (s_busy !== (i < pr + 2)) nbusy_err++;
            if (s_bank !== exp_bank) nbank_err++;
            if (int'(s_addr) > maxaddr) maxaddr = int'(s_addr);
            if (i == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                chk_reset_vals("midline_reset");
                reset = 1'b0;
                quiet = 0;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    if (s_done !== 1'b0 || s_v !== 1'b0 || s_busy !== 1'b0) quiet++;
                end
                chk("midline_reset_quiet", quiet, 0);
                chk("midline_reset_partial_done", ndone, 0);
                mb[0] = 1'b0;
                mb[1] = 1'b0;
                return;
            end
        end
        chk("valid_count",   nvalid,    pr);
        chk("valid_pattern", nv_err,    0);
        chk("pixel_stream",  np_err,    0);
        chk("done_count",    ndone,     1);
        chk("done_index",    done_idx,  pr + 1);
        chk("busy_window",   nbusy_err, 0);
        chk("bank_track",    nbank_err, 0);
        chk("addr_peak",     maxaddr,   P - 1);
        chk("addr_idle",     32'(s_addr), 0);
        mb[sel] = ~mb[sel];
    endtask

    initial begin
        mb[0] = 1'b0;
        mb[1] = 1'b0;
        for (int k = 0; k < P; k++) mem[k] = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk_reset_vals("reset_held");
        end
        reset = 1'b0;
        sel   = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset_released");

        // REPEAT=1: k mod 16 pattern, then a back-to-back random line
        run_line(1, 1'b0, -1, -1);
        chk("ovr_after_line1", 32'(s_ovr), 0);
        run_line(1, 1'b1, -1, -1);
        chk("ovr_back_to_back", 32'(s_ovr), 0);

        // extra line_start at pixel 600 is ignored but sets sticky overrun
        run_line(1, 1'b1, 600, -1);
        chk("ovr_set", 32'(s_ovr), 1);
        run_line(1, 1'b1, -1, -1);
        chk("ovr_sticky", 32'(s_ovr), 1);

        // reset at pixel 300, then a clean restart from address 0
        run_line(1, 1'b1, -1, 302);
        run_line(1, 1'b1, -1, -1);
        chk("ovr_after_reset", 32'(s_ovr), 0);

        // REPEAT=2 instance, two back-to-back lines
        sel = 1'b1;
        run_line(2, 1'b1, -1, -1);
        run_line(2, 1'b1, -1, -1);
        chk("ovr_rep2", 32'(s_ovr), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
